// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared opcode and FSM state types for the arbitrated ALU
package alu_arb_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_ADD = 3'b011,
    OP_SUB = 3'b100,
    OP_NOT = 3'b101
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    HOLD = 2'b10
  } estado_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational M-bit ALU core with carry/borrow and illegal-opcode flag
module alu_core
  import alu_arb_pkg::*;
#(
  parameter int M = 4
) (
  input  logic [M-1:0] expA,
  input  logic [M-1:0] expB,
  input  op_t          op,
  output logic [M-1:0] resultado,
  output logic         acarreo,
  output logic         illegal
);

  logic [M:0] suma;
  logic [M:0] resta;

  // The extra top bit of the widened difference is the unsigned borrow.
  assign suma  = {1'b0, expA} + {1'b0, expB};
  assign resta = {1'b0, expA} - {1'b0, expB};

  always_comb begin
    resultado = '0;
    acarreo   = 1'b0;
    illegal   = 1'b0;
    case (op)
      OP_AND: resultado = expA & expB;
      OP_OR:  resultado = expA | expB;
      OP_XOR: resultado = expA ^ expB;
      OP_ADD: begin
        resultado = suma[M-1:0];
        acarreo   = suma[M];
      end
      OP_SUB: begin
        resultado = resta[M-1:0];
        acarreo   = resta[M];
      end
      OP_NOT: resultado = ~expA;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbitro.sv
// rtl/alu_arbitro.sv - round-robin two-port arbiter and sequencer around alu_core
// Optional err output for illegal opcodes when ALU_ARB_ERR_EN is defined.
module alu_arbitro
  import alu_arb_pkg::*;
#(
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_a,
  output logic         ready_a,
  input  logic [M-1:0] expA_a,
  input  logic [M-1:0] expB_a,
  input  logic [2:0]   op_a,
  input  logic         valid_b,
  output logic         ready_b,
  input  logic [M-1:0] expA_b,
  input  logic [M-1:0] expB_b,
  input  logic [2:0]   op_b,
  output logic [M-1:0] resultado,
  output logic         cero,
  output logic         acarreo,
  output logic         id,
  output logic         valid_out,
  input  logic         ready_out
`ifdef ALU_ARB_ERR_EN
  ,
  output logic         err
`endif
);

  estado_t      estado, estado_sig;
  logic         last;
  logic         grant_b;
  logic         acepta;
  logic [M-1:0] opA_q, opB_q;
  op_t          op_q;
  logic [M-1:0] core_res;
  logic         core_carry;
  logic         core_illegal;

  // B wins when it is alone, or on a tie when A was served last.
  assign grant_b = valid_b & (~valid_a | ~last);
  assign ready_a = ~rst & (estado == IDLE) & valid_a & ~grant_b;
  assign ready_b = ~rst & (estado == IDLE) & grant_b;
  assign acepta  = ready_a | ready_b;

  alu_core #(.M(M)) u_core (
    .expA      (opA_q),
    .expB      (opB_q),
    .op        (op_q),
    .resultado (core_res),
    .acarreo   (core_carry),
    .illegal   (core_illegal)
  );

  always_comb begin
    estado_sig = estado;
    case (estado)
      IDLE:    if (acepta) estado_sig = EXEC;
      EXEC:    estado_sig = HOLD;
      HOLD:    if (ready_out) estado_sig = IDLE;
      default: estado_sig = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado    <= IDLE;
      last      <= 1'b1;
      opA_q     <= '0;
      opB_q     <= '0;
      op_q      <= OP_AND;
      resultado <= '0;
      cero      <= 1'b0;
      acarreo   <= 1'b0;
      id        <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      estado <= estado_sig;
      case (estado)
        IDLE: if (acepta) begin
          opA_q <= grant_b ? expA_b : expA_a;
          opB_q <= grant_b ? expB_b : expB_a;
          op_q  <= op_t'(grant_b ? op_b : op_a);
          id    <= grant_b;
        end
        EXEC: begin
          // Illegal opcodes always report a zero result with no carry.
          resultado <= core_illegal ? '0 : core_res;
          cero      <= core_illegal | (core_res == '0);
          acarreo   <= core_carry & ~core_illegal;
          valid_out <= 1'b1;
        end
        HOLD: if (ready_out) begin
          last      <= id;
          valid_out <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ARB_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err <= 1'b0;
    else if (estado == EXEC)
      err <= core_illegal;
    else if (estado == HOLD && ready_out)
      err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_alu_arbitro.sv
// tb/tb_alu_arbitro.sv - self-checking bench for alu_arbitro against an arithmetic reference model
module tb_alu_arbitro;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_a, ready_a, valid_b, ready_b;
  logic [3:0] expA_a, expB_a, expA_b, expB_b;
  logic [2:0] op_a, op_b;
  logic [3:0] resultado;
  logic       cero, acarreo, id, valid_out, ready_out;
`ifdef ALU_ARB_ERR_EN
  logic       err;
`endif

  int tests = 0;
  int failures = 0;
  logic last_m;

  always #5 clk = ~clk;

  alu_arbitro #(.M(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_a   (valid_a),
    .ready_a   (ready_a),
    .expA_a    (expA_a),
    .expB_a    (expB_a),
    .op_a      (op_a),
    .valid_b   (valid_b),
    .ready_b   (ready_b),
    .expA_b    (expA_b),
    .expB_b    (expB_b),
    .op_b      (op_b),
    .resultado (resultado),
    .cero      (cero),
    .acarreo   (acarreo),
    .id        (id),
    .valid_out (valid_out),
    .ready_out (ready_out)
`ifdef ALU_ARB_ERR_EN
    ,
    .err       (err)
`endif
  );

  // Reference: plain integer arithmetic on unsigned operands.
  task automatic model(input logic [2:0] o, input int x, input int y,
                       output logic [3:0] r, output logic c, output logic e);
    int v;
    v = 0; c = 1'b0; e = 1'b0;
    case (o)
      3'd0: v = x & y;
      3'd1: v = x | y;
      3'd2: v = x ^ y;
      3'd3: begin v = x + y; c = (v >= 16); end
      3'd4: begin v = x - y + 16; c = (x < y); end
      3'd5: v = 15 - x;
      default: begin v = 0; e = 1'b1; end
    endcase
    r = 4'(v % 16);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; ready_out = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_out(output logic ok);
    int n;
    n = 0;
    #1;
    while (valid_out !== 1'b1 && n < 10) begin
      @(negedge clk); #1; n++;
    end
    ok = (valid_out === 1'b1);
  endtask

  task automatic handshake();
    ready_out = 1'b1;
    @(negedge clk);
    ready_out = 1'b0;
  endtask

  task automatic run_op(input logic who, input logic [2:0] o, input logic [3:0] x, input logic [3:0] y,
                        output logic [3:0] r, output logic z, output logic c, output logic i,
                        output logic e, output logic ok);
    int n;
    n = 0;
    if (who) begin valid_b = 1'b1; op_b = o; expA_b = x; expB_b = y; end
    else     begin valid_a = 1'b1; op_a = o; expA_a = x; expB_a = y; end
    #1;
    while (!(who ? ready_b : ready_a) && n < 10) begin
      @(negedge clk); #1; n++;
    end
    ok = who ? ready_b : ready_a;
    @(negedge clk);
    valid_a = 1'b0; valid_b = 1'b0;
    wait_out(ok);
    r = resultado; z = cero; c = acarreo; i = id;
`ifdef ALU_ARB_ERR_EN
    e = err;
`else
    e = 1'b0;
`endif
    handshake();
  endtask

  task automatic test_reset();
    logic ok;
    rst = 1'b1; ready_out = 1'b0; valid_b = 1'b0;
    valid_a = 1'b1; op_a = 3'd1; expA_a = 4'h3; expB_a = 4'h4;
    @(negedge clk); #1;
    tests++;
    if (ready_a !== 1'b0 || valid_out !== 1'b0 || resultado !== 4'h0 || cero !== 1'b0 ||
        acarreo !== 1'b0 || id !== 1'b0)
      begin failures++; $display("FAIL reset_state: ready_a=%b valid_out=%b res=%h cero=%b acarreo=%b id=%b, want all 0",
                                 ready_a, valid_out, resultado, cero, acarreo, id); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (ready_a !== 1'b1) begin failures++; $display("FAIL reset_first_accept: ready_a=%b want 1", ready_a); end
    @(negedge clk);
    valid_a = 1'b0;
    wait_out(ok);
    tests++;
    if (!ok || resultado !== 4'h7) begin failures++; $display("FAIL reset_first_op: ok=%b res=%h want 7", ok, resultado); end
    handshake();
  endtask

  task automatic test_single_or();
    logic [3:0] r; logic z, c, i, e, ok;
    do_reset();
    run_op(1'b0, 3'd1, 4'b1010, 4'b0101, r, z, c, i, e, ok);
    tests++;
    if (!ok || r !== 4'b1111 || z !== 1'b0 || c !== 1'b0 || i !== 1'b0)
      begin failures++; $display("FAIL single_or: ok=%b res=%b cero=%b acarreo=%b id=%b want 1111 0 0 0", ok, r, z, c, i); end
  endtask

  task automatic test_tie();
    logic ok;
    do_reset();
    valid_a = 1'b1; op_a = 3'd3; expA_a = 4'b0001; expB_a = 4'b0001;
    valid_b = 1'b1; op_b = 3'd4; expA_b = 4'b0011; expB_b = 4'b0011;
    #1;
    tests++;
    if (ready_a !== 1'b1 || ready_b !== 1'b0) begin failures++; $display("FAIL tie_first: ready_a=%b ready_b=%b want 1 0", ready_a, ready_b); end
    @(negedge clk);
    valid_a = 1'b0;
    wait_out(ok);
    tests++;
    if (!ok || resultado !== 4'b0010 || id !== 1'b0)
      begin failures++; $display("FAIL tie_a_result: ok=%b res=%b id=%b want 0010 0", ok, resultado, id); end
    handshake();
    #1;
    tests++;
    if (ready_b !== 1'b1) begin failures++; $display("FAIL tie_b_accept: ready_b=%b want 1", ready_b); end
    @(negedge clk);
    valid_b = 1'b0;
    wait_out(ok);
    tests++;
    if (!ok || resultado !== 4'b0000 || cero !== 1'b1 || acarreo !== 1'b0 || id !== 1'b1)
      begin failures++; $display("FAIL tie_b_result: ok=%b res=%b cero=%b acarreo=%b id=%b want 0000 1 0 1", ok, resultado, cero, acarreo, id); end
    handshake();
  endtask

  task automatic test_overflow();
    logic [3:0] r; logic z, c, i, e, ok;
    run_op(1'b0, 3'd3, 4'b1111, 4'b0001, r, z, c, i, e, ok);
    tests++;
    if (!ok || r !== 4'b0000 || z !== 1'b1 || c !== 1'b1)
      begin failures++; $display("FAIL add_overflow: ok=%b res=%b cero=%b acarreo=%b want 0000 1 1", ok, r, z, c); end
    run_op(1'b1, 3'd4, 4'b0001, 4'b0010, r, z, c, i, e, ok);
    tests++;
    if (!ok || r !== 4'b1111 || z !== 1'b0 || c !== 1'b1 || i !== 1'b1)
      begin failures++; $display("FAIL sub_borrow: ok=%b res=%b cero=%b acarreo=%b id=%b want 1111 0 1 1", ok, r, z, c, i); end
  endtask

  task automatic test_backpressure();
    logic ok;
    valid_a = 1'b1; op_a = 3'd2; expA_a = 4'b1100; expB_a = 4'b1010;
    #1;
    tests++;
    if (ready_a !== 1'b1) begin failures++; $display("FAIL bp_accept_a: ready_a=%b want 1", ready_a); end
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b1; op_b = 3'd3; expA_b = 4'b0011; expB_b = 4'b0100;
    wait_out(ok);
    tests++;
    if (!ok || resultado !== 4'b0110) begin failures++; $display("FAIL bp_result: ok=%b res=%b want 0110", ok, resultado); end
    repeat (5) begin
      @(negedge clk); #1;
      tests++;
      if (valid_out !== 1'b1 || resultado !== 4'b0110 || id !== 1'b0 || ready_a !== 1'b0 || ready_b !== 1'b0)
        begin failures++; $display("FAIL bp_hold: valid_out=%b res=%b id=%b ready_a=%b ready_b=%b want 1 0110 0 0 0",
                                   valid_out, resultado, id, ready_a, ready_b); end
    end
    handshake();
    #1;
    tests++;
    if (ready_b !== 1'b1 || valid_out !== 1'b0) begin failures++; $display("FAIL bp_b_next: ready_b=%b valid_out=%b want 1 0", ready_b, valid_out); end
    @(negedge clk);
    valid_b = 1'b0;
    wait_out(ok);
    tests++;
    if (!ok || resultado !== 4'b0111 || id !== 1'b1) begin failures++; $display("FAIL bp_b_result: ok=%b res=%b id=%b want 0111 1", ok, resultado, id); end
    handshake();
  endtask

  task automatic test_illegal();
    logic [3:0] r; logic z, c, i, e, ok;
    run_op(1'b0, 3'b110, 4'b1011, 4'b0110, r, z, c, i, e, ok);
    tests++;
    if (!ok || r !== 4'b0000 || z !== 1'b1 || c !== 1'b0)
      begin failures++; $display("FAIL illegal_op: ok=%b res=%b cero=%b acarreo=%b want 0000 1 0", ok, r, z, c); end
`ifdef ALU_ARB_ERR_EN
    tests++;
    if (e !== 1'b1) begin failures++; $display("FAIL illegal_err: err=%b want 1", e); end
    #1;
    tests++;
    if (err !== 1'b0) begin failures++; $display("FAIL err_clear: err=%b want 0", err); end
`endif
  endtask

  task automatic test_midreset();
    valid_a = 1'b1; op_a = 3'd3; expA_a = 4'h5; expB_a = 4'h6;
    @(negedge clk);
    valid_a = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      tests++;
      if (valid_out !== 1'b0 || ready_a !== 1'b0)
        begin failures++; $display("FAIL midreset_drop: valid_out=%b ready_a=%b want 0 0", valid_out, ready_a); end
    end
    valid_a = 1'b1; valid_b = 1'b1;
    #1;
    tests++;
    if (ready_a !== 1'b1 || ready_b !== 1'b0)
      begin failures++; $display("FAIL midreset_idle: ready_a=%b ready_b=%b want 1 0", ready_a, ready_b); end
    do_reset();
  endtask

  task automatic test_random();
    logic pa, pb, gb, ec, ee;
    logic [2:0] a_op, b_op, oo;
    logic [3:0] a_x, a_y, b_x, b_y, xx, yy, er;
    int k;
    do_reset();
    last_m = 1'b1;
    pa = 1'b0; pb = 1'b0;
    a_op = '0; b_op = '0; a_x = '0; a_y = '0; b_x = '0; b_y = '0;
    for (int n = 0; n < 60; n++) begin
      if (!pa) begin
        a_op = 3'($urandom); a_x = 4'($urandom); a_y = 4'($urandom); pa = ($urandom_range(0, 2) != 0);
      end
      if (!pb) begin
        b_op = 3'($urandom); b_x = 4'($urandom); b_y = 4'($urandom); pb = ($urandom_range(0, 2) != 0);
      end
      if (!pa && !pb) pa = 1'b1;
      valid_a = pa; op_a = a_op; expA_a = a_x; expB_a = a_y;
      valid_b = pb; op_b = b_op; expA_b = b_x; expB_b = b_y;
      #1;
      gb = pb && (!pa || !last_m);
      tests++;
      if (ready_a !== (pa && !gb) || ready_b !== gb)
        begin failures++; $display("FAIL rnd_grant[%0d]: ready_a=%b ready_b=%b want %b %b", n, ready_a, ready_b, pa && !gb, gb); end
      oo = gb ? b_op : a_op; xx = gb ? b_x : a_x; yy = gb ? b_y : a_y;
      model(oo, int'(xx), int'(yy), er, ec, ee);
      @(negedge clk);
      if (gb) pb = 1'b0; else pa = 1'b0;
      valid_a = pa; valid_b = pb;
      #1;
      tests++;
      if (valid_out !== 1'b0) begin failures++; $display("FAIL rnd_latency[%0d]: valid_out=%b want 0", n, valid_out); end
      @(negedge clk); #1;
      tests++;
      if (valid_out !== 1'b1 || resultado !== er || cero !== (er == 4'h0) || acarreo !== ec || id !== gb)
        begin failures++; $display("FAIL rnd_result[%0d]: op=%b v=%b res=%h cero=%b acarreo=%b id=%b want 1 %h %b %b %b",
                                   n, oo, valid_out, resultado, cero, acarreo, id, er, er == 4'h0, ec, gb); end
`ifdef ALU_ARB_ERR_EN
      tests++;
      if (err !== ee) begin failures++; $display("FAIL rnd_err[%0d]: err=%b want %b", n, err, ee); end
`endif
      k = $urandom_range(0, 3);
      repeat (k) begin
        @(negedge clk); #1;
        tests++;
        if (valid_out !== 1'b1 || resultado !== er || ready_a !== 1'b0 || ready_b !== 1'b0)
          begin failures++; $display("FAIL rnd_hold[%0d]: v=%b res=%h ra=%b rb=%b want 1 %h 0 0", n, valid_out, resultado, ready_a, ready_b, er); end
      end
      handshake();
      last_m = gb;
    end
    valid_a = 1'b0; valid_b = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ready_out = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0;
    op_a = '0; op_b = '0; expA_a = '0; expB_a = '0; expA_b = '0; expB_b = '0;
    test_reset();
    test_single_or();
    test_tie();
    test_overflow();
    test_backpressure();
    test_illegal();
    test_midreset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbitro.md
# alu_arbitro

Two-port arbiter and sequencer for the lab ALU datapath. It shares one M-bit ALU core between two requesters (A and B) using round-robin grant, and registers the operands and opcode of the granted request. It executes the operation, then presents a registered result with zero/carry flags and requester id on a valid/ready output channel. It sits between the lab control logic or testbench drivers and the result consumer.

## Interface
- `M`, default 4: operand and result width.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous and active-high.
- `valid_a` in 1: requester A has an operation pending.
- `ready_a` out 1: A's operation is accepted this cycle.
- `expA_a`, `expB_a` in M: A's operands.
- `op_a` in 3: A's opcode.
- `valid_b`, `ready_b`, `expA_b`, `expB_b`, `op_b`: same set for requester B.
- `resultado` out M: registered result.
- `cero` out 1: high when `resultado` == 0.
- `acarreo` out 1: carry (ADD) or borrow (SUB), otherwise 0.
- `id` out 1: requester that owns the result (0 = A, 1 = B).
- `valid_out` out 1: result is valid.
- `ready_out` in 1: consumer accepts the result.
- `err` out 1: present only with `ALU_ARB_ERR_EN`.

## Operation
- **Opcodes:**
  - 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB (A−B), 101 NOT A.
  - 110 and 111 are illegal and produce result 0.
- **FSM states:** IDLE, EXEC, HOLD.
- **IDLE:**
  - Grant is combinational.
  - Only one valid: that requester is granted.
  - Both valid: the requester other than `last` is granted.
  - `ready_x` = (state==IDLE) & grant==x & valid_x.
  - On accept, capture operands, opcode and id, then go to EXEC.
- **EXEC:** register the ALU core outputs into `resultado`, `cero`, `acarreo` (and `err`), set `valid_out`, go to HOLD.
- **HOLD:**
  - `valid_out`=1 and outputs are held stable.
  - On `valid_out & ready_out`: `last` ← `id`, `valid_out` ← 0, go to IDLE.
- **Arithmetic:**
  - ADD: result = (A+B) mod 2^M, `acarreo` = bit M of the sum.
  - SUB: result = (A−B) mod 2^M, `acarreo` = 1 iff A<B unsigned.
  - All other opcodes: `acarreo`=0.
- **Requester rules:**
  - Hold `valid_x` and data stable until `ready_x`.
  - `valid_x` must not depend on `ready_x`.
  - Operand changes after accept are ignored.
- **Reset values:**
  - state=IDLE, `last`=1 (A wins the first tie).
  - `resultado`=0, `cero`=0, `acarreo`=0, `id`=0, `valid_out`=0, `err`=0.
  - `ready_a`/`ready_b` are 0 during reset.
- **Reset mid-operation:** the in-flight op is dropped, no result is emitted, and the requester is not re-acked.

## Timing
- Accept in cycle t (ready_x high). `valid_out` rises at the clock edge ending cycle t+1, so it is visible in cycle t+2.
- Earliest next accept: the cycle after the output handshake.
- Minimum period with `ready_out` tied 1: 3 cycles per op.
- Output handshake completes in the cycle `ready_out` is sampled high while `valid_out`=1.
- No combinational path from `ready_out` to `ready_a`/`ready_b`.
- Alternation is guaranteed when both requesters are continuously valid: A, B, A, B…

## Configuration
- **`ALU_ARB_ERR_EN` defined:**
  - `err` port exists.
  - `err` is registered in EXEC as 1 for opcodes 110/111, else 0.
  - `err` is held in HOLD and cleared on handshake.
- **Not defined:** no `err` port. Illegal opcodes silently yield result 0, `cero`=1, `acarreo`=0.

## Structure
- Package `alu_arb_pkg`:
  - `typedef enum logic [2:0] op_t` (OP_AND…OP_NOT).
  - `typedef enum logic [1:0] estado_t` (IDLE, EXEC, HOLD).
- One sub-module `alu_core`: combinational `#(M)`, inputs expA, expB, op_t; outputs resultado, acarreo, illegal.
- Arbiter, FSM and output registers live in `alu_arbitro`.

## Test plan
- **Reset:** assert `rst` with `valid_a`=1 → `ready_a`=0, `valid_out`=0, `resultado`=0000. After release, A is accepted on the first IDLE cycle.
- **Single OR:** A sends 1010 OR 0101 → 2 cycles after accept, `resultado`=1111, `cero`=0, `acarreo`=0, `id`=0.
- **Tie from reset:** A sends ADD 0001+0001, B sends SUB 0011−0011, both held valid.
  - A served first: 0010, `id`=0.
  - B served next: 0000, `cero`=1, `acarreo`=0, `id`=1.
- **Overflow and borrow:**
  - ADD 1111+0001 → 0000, `cero`=1, `acarreo`=1.
  - SUB 0001−0010 → 1111, `acarreo`=1.
- **Backpressure:** `ready_out`=0 for 5 cycles in HOLD with `valid_b`=1 → outputs stable, `ready_a`/`ready_b`=0. `ready_out`=1 → handshake, then B accepted next cycle.
- **Illegal opcode and mid-op reset:**
  - op 110 with `ALU_ARB_ERR_EN` → `err`=1, `resultado`=0000.
  - `rst` pulsed in EXEC → `valid_out` stays 0, FSM returns to IDLE.
